// File: rtl/vc_input_buffer.sv
// Router input unit: per-VC FIFOs with a registered dimension-order torus route.
// Heads go to the crossbar, or to a round-robin eject port when the flit is local.
module vc_input_buffer #(
    parameter int VC_NUM    = 2,
    parameter int BUF_DEPTH = 4,
    parameter int DIM_SIZE  = 4,
    parameter int FLIT_SIZE = 16,
    parameter int ROUTE_LEN = 3,
    parameter int COORD_W   = $clog2(DIM_SIZE),
    parameter int VC_W      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [COORD_W-1:0]             cur_x,
    input  logic [COORD_W-1:0]             cur_y,
    input  logic [COORD_W-1:0]             cur_z,
    input  logic [FLIT_SIZE-1:0]           link_in,
    input  logic                           link_valid,
    output logic [VC_NUM-1:0]              link_avail,
    output logic [VC_NUM*FLIT_SIZE-1:0]    sw_out,
    output logic [VC_NUM*ROUTE_LEN-1:0]    sw_route,
    output logic [VC_NUM-1:0]              sw_valid,
    input  logic [VC_NUM-1:0]              sw_avail,
    output logic [FLIT_SIZE-1:0]           eject_out,
    output logic                           eject_valid,
    input  logic                           eject_avail
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ROUTE_LEN-1:0] DIR_LOCAL = '0;
    localparam logic [ROUTE_LEN-1:0] DIR_XPOS  = ROUTE_LEN'(1);
    localparam logic [ROUTE_LEN-1:0] DIR_XNEG  = ROUTE_LEN'(2);
    localparam logic [ROUTE_LEN-1:0] DIR_YPOS  = ROUTE_LEN'(3);
    localparam logic [ROUTE_LEN-1:0] DIR_YNEG  = ROUTE_LEN'(4);
    localparam logic [ROUTE_LEN-1:0] DIR_ZPOS  = ROUTE_LEN'(5);
    localparam logic [ROUTE_LEN-1:0] DIR_ZNEG  = ROUTE_LEN'(6);
    localparam logic [COORD_W-1:0]   HALF      = COORD_W'(DIM_SIZE / 2);

    logic [COORD_W-1:0]                    dx, dy, dz;
    logic [ROUTE_LEN-1:0]                  in_route;
    logic [VC_W-1:0]                       in_vc;
    logic [VC_NUM-1:0]                     push, pop, full, not_empty, eject_cand;
    logic [VC_NUM-1:0][FLIT_SIZE-1:0]      head_flit;
    logic [VC_NUM-1:0][ROUTE_LEN-1:0]      head_route;
    logic [VC_W-1:0]                       rr, eject_sel;
    logic                                  eject_fire;

    // Offsets wrap naturally in COORD_W bits, giving the forward ring distance.
    assign dx    = link_in[COORD_W-1:0]           - cur_x;
    assign dy    = link_in[2*COORD_W-1:COORD_W]   - cur_y;
    assign dz    = link_in[3*COORD_W-1:2*COORD_W] - cur_z;
    assign in_vc = link_in[3*COORD_W +: VC_W];

    always_comb begin
        in_route = DIR_LOCAL;
        if (dx != '0)      in_route = (dx <= HALF) ? DIR_XPOS : DIR_XNEG;
        else if (dy != '0) in_route = (dy <= HALF) ? DIR_YPOS : DIR_YNEG;
        else if (dz != '0) in_route = (dz <= HALF) ? DIR_ZPOS : DIR_ZNEG;
    end

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        logic [ROUTE_LEN+FLIT_SIZE-1:0] mem [BUF_DEPTH];
        logic [PTR_W-1:0]               rd_ptr, wr_ptr;
        logic [CNT_W-1:0]               cnt;

        assign full[v]       = (cnt == CNT_W'(BUF_DEPTH));
        assign not_empty[v]  = (cnt != '0);
        assign link_avail[v] = !full[v] && rst;
        assign push[v]       = link_valid && link_avail[v] && (in_vc == VC_W'(v));
        assign pop[v]        = (sw_valid[v] && sw_avail[v])
                             || (eject_fire && (eject_sel == VC_W'(v)));

        assign {head_route[v], head_flit[v]} = mem[rd_ptr];
        assign sw_valid[v]   = not_empty[v] && (head_route[v] != DIR_LOCAL);
        assign eject_cand[v] = not_empty[v] && (head_route[v] == DIR_LOCAL);

        // NOTE: sequential state uses <= so every block samples pre-edge values.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[v]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[v])  rd_ptr <= rd_ptr + 1'b1;
                case ({push[v], pop[v]})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        // NOTE: storage has no reset; the count alone decides which entries are live.
        always_ff @(posedge clk) begin
            if (push[v]) mem[wr_ptr] <= {in_route, link_in};
        end
    end

    assign sw_out   = head_flit;
    assign sw_route = head_route;

    // First local head at or after rr wins the eject port.
    always_comb begin
        logic [VC_W:0] idx;
        idx         = '0;
        eject_sel   = '0;
        eject_valid = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = {1'b0, rr} + (VC_W+1)'(i);
            if (idx >= (VC_W+1)'(VC_NUM)) idx = idx - (VC_W+1)'(VC_NUM);
            if (!eject_valid && eject_cand[idx[VC_W-1:0]]) begin
                eject_valid = 1'b1;
                eject_sel   = idx[VC_W-1:0];
            end
        end
    end

    assign eject_out  = head_flit[eject_sel];
    assign eject_fire = eject_valid && eject_avail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr <= '0;
        end else if (eject_fire) begin
            rr <= (eject_sel == VC_W'(VC_NUM - 1)) ? '0 : eject_sel + 1'b1;
        end
    end

endmodule
